// File: rtl/frame_builder.sv
// Serializes a 64-bit payload into a 13-byte command frame over a valid/ready byte stream.
// Define FRAMER_GAP_EN to insert GAP_CYCLES idle cycles after every byte except the tail.
`timescale 1ns/1ps
module frame_builder #(
  parameter logic [7:0] HEADER     = 8'h52,
  parameter logic [7:0] LENGTH     = 8'h0E,
  parameter logic [7:0] CMD        = 8'h01,
  parameter logic [7:0] TAIL       = 8'h9A,
  parameter int         GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        En,
  input  logic        start,
  input  logic [63:0] payload,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fBusy,
  output logic        fDone
);

`ifdef FRAMER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam bit          GAP_ON   = GAP_EN && (GAP_CYCLES > 0);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LENGTH, S_CMD, S_DATA, S_CHECK, S_TAIL, S_GAP
  } state_t;

  // Handshake: a byte moves on a posedge where tx_valid && tx_ready; tx_data and
  // tx_valid hold until then, and tx_ready is ignored while tx_valid is low.
  state_t      state;
  state_t      adv_state;
  state_t      nxt;
  logic [63:0] pay_q;
  logic [7:0]  acc;
  logic [7:0]  acc_next;
  logic [7:0]  adv_byte;
  logic [2:0]  cnt;
  logic [15:0] gap_cnt;

  // Next state, next byte and running sum for the transfer of the byte on the wire.
  always_comb begin
    adv_state = S_IDLE;
    adv_byte  = 8'h00;
    acc_next  = acc;
    case (state)
      S_HEADER: begin
        adv_state = S_LENGTH;
        adv_byte  = LENGTH;
        acc_next  = acc + LENGTH;
      end
      S_LENGTH: begin
        adv_state = S_CMD;
        adv_byte  = CMD;
        acc_next  = acc + CMD;
      end
      S_CMD: begin
        adv_state = S_DATA;
        adv_byte  = pay_q[63:56];
      end
      S_DATA: begin
        acc_next = acc + tx_data;
        if (cnt == 3'd7) begin
          adv_state = S_CHECK;
          adv_byte  = 8'h01 - (acc_next + TAIL);
        end else begin
          adv_state = S_DATA;
          adv_byte  = pay_q[55:48];
        end
      end
      S_CHECK: begin
        adv_state = S_TAIL;
        adv_byte  = TAIL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !En) begin
      state    <= S_IDLE;
      nxt      <= S_IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      fBusy    <= 1'b0;
      fDone    <= 1'b0;
      pay_q    <= 64'h0;
      acc      <= 8'h00;
      cnt      <= 3'd0;
      gap_cnt  <= 16'd0;
    end else begin
      fDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pay_q    <= payload;
            cnt      <= 3'd0;
            acc      <= HEADER;
            fBusy    <= 1'b1;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            state    <= S_HEADER;
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            state    <= nxt;
            tx_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          if (tx_ready) begin
            acc     <= acc_next;
            tx_data <= adv_byte;
            if (state == S_DATA) begin
              cnt   <= cnt + 3'd1;
              pay_q <= {pay_q[55:0], 8'h00};
            end
            if (state == S_TAIL) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
              fBusy    <= 1'b0;
              fDone    <= 1'b1;
            end else if (GAP_ON) begin
              // Next byte waits in tx_data with tx_valid low until the gap expires.
              state    <= S_GAP;
              nxt      <= adv_state;
              tx_valid <= 1'b0;
              gap_cnt  <= GAP_LOAD;
            end else begin
              state <= adv_state;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder: table vectors, random frames against a frame model,
// and hand-written sequences for restart, re-pulse and abort corners.
`timescale 1ns/1ps
module tb_frame_builder;
  localparam logic [7:0] HDR  = 8'h52;
  localparam logic [7:0] LEN  = 8'h0E;
  localparam logic [7:0] CMDB = 8'h01;
  localparam logic [7:0] TL   = 8'h9A;
`ifdef FRAMER_GAP_EN
  localparam int GAP_EXP = 4;
`else
  localparam int GAP_EXP = 0;
`endif
  localparam int LAT_EXP = 14 + 12 * GAP_EXP;

  logic        clk = 1'b0;
  logic        rst_n, en, start, tx_ready;
  logic [63:0] payload;
  logic [7:0]  tx_data;
  logic        tx_valid, fbusy, fdone;

  frame_builder dut (
    .clk(clk), .rst_n(rst_n), .En(en), .start(start), .payload(payload),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fBusy(fbusy), .fDone(fdone)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, gap_total = 0;
  bit   rdy_rand = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       prv_v = 1'b0, prv_r = 1'b0, prv_en = 1'b0;
  logic [7:0] prv_d = 8'h00;

  typedef struct {
    logic [63:0] p;
    logic [7:0]  chk;
  } vec_t;
  vec_t vecs[4];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor on the falling edge: records transfers, done pulses, gap cycles, hold stability.
  initial forever begin
    logic live;
    @(negedge clk);
    live = rst_n && en;
    if (live && fdone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (live && fbusy && !tx_valid) gap_total++;
    if (live && tx_valid && tx_ready) got_q.push_back(tx_data);
    if (prv_en && live && prv_v && !prv_r) begin
      checks++;
      if (!tx_valid || tx_data != prv_d) begin
        errors++;
        $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                 tx_valid, tx_data, prv_d);
      end
    end
    prv_v  = tx_valid;
    prv_r  = tx_ready;
    prv_d  = tx_data;
    prv_en = live;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tx_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
  endtask

  // Frame model: fixed header bytes, payload MSB-first, checksum making the 13-byte sum 01.
  task automatic model_push(input logic [63:0] p);
    logic [7:0] b[13];
    logic [7:0] sum;
    b[0] = HDR;
    b[1] = LEN;
    b[2] = CMDB;
    for (int k = 0; k < 8; k++) b[3 + k] = p[(7 - k) * 8 +: 8];
    sum = 8'h00;
    for (int k = 0; k < 11; k++) sum = sum + b[k];
    b[11] = 8'h01 - sum - TL;
    b[12] = TL;
    for (int k = 0; k < 13; k++) exp_q.push_back(b[k]);
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 800 && done_cnt < target; i++) tick();
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic compare_stream(input string name);
    logic [7:0] sum;
    chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    for (int f = 0; f + 13 <= got_q.size(); f += 13) begin
      sum = 8'h00;
      for (int i = 0; i < 13; i++) sum = sum + got_q[f + i];
      chk($sformatf("%s_sum%0d", name, f / 13), 64'(sum), 64'h01);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [63:0] p, input bit rnd, output int lat);
    int d0, st;
    d0 = done_cnt;
    model_push(p);
    rdy_rand  = rnd;
    gap_total = 0;
    start     = 1'b1;
    payload   = p;
    st        = cyc;
    tick();
    start   = 1'b0;
    payload = {$urandom, $urandom};
    chk("hdr_valid", 64'(tx_valid), 64'h1);
    chk("hdr_data", 64'(tx_data), 64'(HDR));
    chk("hdr_busy", 64'(fbusy), 64'h1);
    wait_done(d0 + 1, "frame");
    lat = done_cyc - st;
    repeat (3) tick();
    chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("gap_total", 64'(gap_total), 64'(12 * GAP_EXP));
    rdy_rand = 1'b0;
  endtask

  initial begin
    int lat, d0;
    logic [63:0] p1, p2;
    rst_n = 1'b0; en = 1'b1; start = 1'b0; payload = 64'h0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_data", 64'(tx_data), 64'h0);
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_busy", 64'(fbusy), 64'h0);
    chk("rst_done", 64'(fdone), 64'h0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{p: 64'h0000000000000000, chk: 8'h06};
    vecs[1] = '{p: 64'h0102030405060708, chk: 8'hE2};
    vecs[2] = '{p: 64'hFFFFFFFFFFFFFFFF, chk: 8'h0E};
    vecs[3] = '{p: 64'h5252525252525252, chk: 8'h76};
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].p, 1'b0, lat);
      chk($sformatf("tbl%0d_latency", v), 64'(lat), 64'(LAT_EXP));
      if (got_q.size() >= 12) chk($sformatf("tbl%0d_chk", v), 64'(got_q[11]), 64'(vecs[v].chk));
      compare_stream($sformatf("tbl%0d", v));
    end

    for (int r = 0; r < 8; r++) begin
      run_frame({$urandom, $urandom}, 1'b1, lat);
      compare_stream($sformatf("rand%0d", r));
    end

    // start re-pulsed mid-frame with a different payload must be ignored
    p1 = 64'hDEADBEEF01234567;
    p2 = 64'h1122334455667788;
    d0 = done_cnt;
    model_push(p1);
    start = 1'b1; payload = p1;
    tick();
    start = 1'b0; payload = p2;
    repeat (3) tick();
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    wait_done(d0 + 1, "repulse");
    repeat (20) tick();
    chk("repulse_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    chk("repulse_idle_busy", 64'(fbusy), 64'h0);
    chk("repulse_idle_valid", 64'(tx_valid), 64'h0);
    compare_stream("repulse");

    // start during the fDone cycle launches the next frame immediately
    d0 = done_cnt;
    model_push(p2);
    model_push(p1);
    start = 1'b1; payload = p2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (fdone) break;
    end
    start = 1'b1; payload = p1;
    tick();
    start = 1'b0;
    chk("b2b_hdr_valid", 64'(tx_valid), 64'h1);
    chk("b2b_hdr_data", 64'(tx_data), 64'(HDR));
    wait_done(d0 + 2, "b2b");
    repeat (3) tick();
    compare_stream("b2b");

    // En dropped while DATA byte 3 is on the wire aborts without fDone
    d0 = done_cnt;
    start = 1'b1; payload = 64'hA5A5A5A5A5A5A5A5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 800 && got_q.size() < 6; i++) tick();
    en = 1'b0;
    tick();
    chk("abort_valid", 64'(tx_valid), 64'h0);
    chk("abort_busy", 64'(fbusy), 64'h0);
    chk("abort_data", 64'(tx_data), 64'h0);
    repeat (10) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    en = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    run_frame(64'h0F1E2D3C4B5A6978, 1'b0, lat);
    chk("reenable_latency", 64'(lat), 64'(LAT_EXP));
    compare_stream("reenable");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_builder.md
Name: frame_builder

Overview:
- Transmit-side counterpart of the 13-byte command frame receiver.
- Accepts a 64-bit payload on a start pulse and serializes it into a framed byte stream: header, length, cmd, 8 data bytes MSB-first, checksum, tail.
- Streams bytes to the UART transmitter over a valid/ready byte handshake.
- Raises fDone when the tail byte has been accepted.

Parameters:
- HEADER, 8'h52, first frame byte
- LENGTH, 8'h0E, second frame byte (constant)
- CMD, 8'h01, third frame byte
- TAIL, 8'h9A, last frame byte
- GAP_CYCLES, 4, idle cycles inserted after each accepted byte (used only with FRAMER_GAP_EN)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  synchronous active-low reset
- En  input  1  block enable; low acts as synchronous clear, same as reset
- start  input  1  request to send one frame; sampled only when fBusy=0
- payload  input  64  frame data; payload[63:56] is sent first
- tx_data  output  8  current frame byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART TX can take a byte; byte is transferred when tx_valid && tx_ready at posedge
- fBusy  output  1  frame in progress
- fDone  output  1  one-cycle pulse: frame completed

Behaviour:
- Reset/enable:
  - While rst_n=0 or En=0 at posedge: state=IDLE, tx_data=0, tx_valid=0, fBusy=0, fDone=0, payload register=0, checksum accumulator=0, byte counter=0.
  - Abort mid-frame is immediate. No partial-frame completion and no fDone.
- States: IDLE, HEADER, LENGTH, CMD, DATA, CHECK, TAIL (plus GAP when the feature is enabled).
- IDLE:
  - fBusy=0, tx_valid=0.
  - start=1 at posedge: latch payload, clear counter, set acc=HEADER, fBusy=1, go to HEADER.
  - tx_valid=1 with tx_data=HEADER from the next cycle (latency 1).
- Byte handshake:
  - In each byte state, tx_data holds the byte and tx_valid=1.
  - tx_data and tx_valid are stable until a cycle with tx_ready=1.
  - On transfer, advance to the next state; the new byte appears the following cycle.
  - tx_valid stays 1 back-to-back if the next byte exists.
  - tx_ready asserted with tx_valid=0 has no effect.
- Transitions:
  - HEADER→LENGTH; acc += LENGTH.
  - LENGTH→CMD; acc += CMD.
  - CMD→DATA.
  - DATA: byte k (k=0..7) = payload[(7-k)*8 +: 8]; acc += byte; counter increments on each transfer. After k=7 transfers, go to CHECK.
  - CHECK: tx_data = chk = 8'h01 - (acc + TAIL), all mod 256. Go to TAIL.
  - TAIL: on transfer, go to IDLE, fBusy=0, fDone=1 for exactly one cycle.
- Checksum rule: 8-bit sum of all 13 bytes (header through tail, including chk) = 8'h01, the receiver's acceptance condition.
- Start rules:
  - start while fBusy=1 is ignored; it is not queued.
  - start during the fDone cycle is accepted, because fBusy is already 0.
- Payload changes after the start cycle do not affect the frame in flight.
- Minimum frame time with tx_ready held at 1: 13 transfer cycles + 1 start cycle; fDone occurs 14 cycles after start.

Optional Feature:
- FRAMER_GAP_EN
- Defined:
  - After every byte transfer except the tail, enter GAP for GAP_CYCLES cycles with tx_valid=0, then present the next byte.
  - fBusy stays 1 during gaps.
  - GAP_CYCLES=0 behaves as undefined.
- Undefined: no GAP state; bytes are back-to-back and the GAP_CYCLES parameter is ignored.

Test Plan:
- Payload 64'h0, tx_ready=1, single start → bytes 52 0E 01 00 00 00 00 00 00 00 00 06 9A on consecutive cycles; fDone pulses once, 14 cycles after start.
- Payload 64'h0102030405060708 → data bytes 01..08 in order, chk=E2, tail 9A; the 8-bit sum of the 13 bytes is 01.
- tx_ready toggled pseudo-randomly → tx_data is stable while tx_valid && !tx_ready; identical 13-byte sequence, no byte dropped or duplicated.
- start re-pulsed mid-frame, and payload changed after start → ignored; the frame carries the originally latched payload. start in the fDone cycle → the next frame's HEADER appears the next cycle.
- En (or rst_n) driven low during DATA byte 3 → next cycle tx_valid=0, fBusy=0, fDone never pulses. After re-enable and a new start, a full correct frame is sent.
- With FRAMER_GAP_EN, GAP_CYCLES=4, tx_ready=1 → exactly 4 cycles of tx_valid=0 between consecutive bytes and none after the tail; fDone occurs 14+12*4=62 cycles after start.
